data_ram_loader: RTL and testbench

- Boot/debug loader upstream of the data RAM. It owns the RAM write port arbitration between the MEM stage and a byte-stream source.
- A load command plus a stream of bytes (valid/ready) is assembled big-endian into 32-bit words, which are written to consecutive word addresses.
- While a load is active the CPU's data-memory requests are stalled through ctrl.
- Outside a load, MEM-stage requests pass straight through to the RAM.

---
 rtl/data_ram_loader.sv | 79 +++++++
 tb/tb_data_ram_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_loader.sv
// data_ram_loader: byte-stream boot loader that owns the data RAM port and stalls the MEM stage while loading.
module data_ram_loader #(
  parameter int CNT_W = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start_i,
  input  logic [31:0]      load_base_i,
  input  logic [CNT_W-1:0] load_words_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             load_busy_o,
  output logic             load_done_o,
  input  logic             cpu_ce_i,
  input  logic             cpu_we_i,
  input  logic [3:0]       cpu_sel_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_data_i,
  output logic [31:0]      cpu_data_o,
  output logic             stallreq_o,
  output logic             ram_ce_o,
  output logic             ram_we_o,
  output logic [3:0]       ram_sel_o,
  output logic [31:0]      ram_addr_o,
  output logic [31:0]      ram_data_o,
  input  logic [31:0]      ram_data_i
);
  localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  logic [1:0] state, byte_cnt, lane;
  logic [CNT_W-1:0] remaining;
  logic [31:0] cur_addr, word;
  logic pass, wr;
  assign pass = state == IDLE || state == DONE;
  assign wr = state == WRITE;
  assign lane = BIG_ENDIAN ? ~byte_cnt : byte_cnt;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      byte_cnt <= '0;
      remaining <= '0;
      cur_addr <= '0;
      word <= '0;
    end else begin
      case (state)
        IDLE: if (load_start_i) begin
          state <= load_words_i != '0 ? RECV : DONE;
          cur_addr <= {load_base_i[31:2], 2'b00};
          remaining <= load_words_i;
          byte_cnt <= '0;
        end
        RECV: if (byte_valid_i) begin
          word[{lane, 3'b000} +: 8] <= byte_data_i;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state <= WRITE;
        end
        WRITE: begin
          cur_addr <= cur_addr + 32'd4;
          remaining <= remaining - CNT_W'(1);
          state <= remaining == CNT_W'(1) ? DONE : RECV;
        end
        default: state <= IDLE;
      endcase
    end
  // CPU requests only reach the RAM in IDLE/DONE; during a load they are held off via stallreq_o
  always_comb begin
    byte_ready_o = !rst && state == RECV;
    load_busy_o = !rst && !pass;
    load_done_o = !rst && state == DONE;
    stallreq_o = !rst && !pass && cpu_ce_i;
    cpu_data_o = !rst && pass && cpu_ce_i && !cpu_we_i ? ram_data_i : '0;
    ram_ce_o = !rst && (pass ? cpu_ce_i : wr);
    ram_we_o = !rst && (pass ? cpu_we_i : wr);
    ram_sel_o = rst ? '0 : pass ? cpu_sel_i : {4{wr}};
    ram_addr_o = rst ? '0 : pass ? cpu_addr_i : wr ? cur_addr : '0;
    ram_data_o = rst ? '0 : pass ? cpu_data_i : wr ? word : '0;
  end
endmodule

// File: tb/tb_data_ram_loader.sv
// tb_data_ram_loader: randomized loads checked against a word-level model of the loader and a RAM model.
module tb_data_ram_loader;
  logic clk = 0, rst = 1;
  logic load_start_i = 0;
  logic [31:0] load_base_i = 0;
  logic [15:0] load_words_i = 0;
  logic byte_valid_i = 0;
  logic [7:0] byte_data_i = 0;
  logic byte_ready_o, load_busy_o, load_done_o;
  logic cpu_ce_i = 0, cpu_we_i = 0;
  logic [3:0] cpu_sel_i = 0;
  logic [31:0] cpu_addr_i = 0, cpu_data_i = 0, cpu_data_o;
  logic stallreq_o, ram_ce_o, ram_we_o;
  logic [3:0] ram_sel_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [31:0] mem [1024];
  logic [31:0] exp_mem [1024];
  int total = 0, bad = 0;

  data_ram_loader dut (
    .clk(clk), .rst(rst),
    .load_start_i(load_start_i), .load_base_i(load_base_i), .load_words_i(load_words_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .load_busy_o(load_busy_o), .load_done_o(load_done_o),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk = ~clk;

  assign ram_data_i = mem[ram_addr_o[11:2]];
  always @(posedge clk)
    if (ram_ce_o && ram_we_o)
      for (int k = 0; k < 4; k++)
        if (ram_sel_o[k]) mem[ram_addr_o[11:2]][8*k +: 8] <= ram_data_o[8*k +: 8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_load(input logic [31:0] base, input int n, input logic [7:0] b[$],
                          input int gap, input logic [31:0] req, input bit stray);
    int idx = 0, w = 0, t = 1;
    bit wr = 0, last = 0, fin = 0;
    logic [31:0] a, d;
    load_start_i = 1;
    load_base_i = base;
    load_words_i = n[15:0];
    cpu_ce_i = 1;
    cpu_we_i = 0;
    cpu_sel_i = 4'hf;
    cpu_addr_i = req;
    @(posedge clk); #1;
    while (!fin && t < 40 * n + 20) begin
      load_start_i = stray && $urandom_range(3) == 0;
      load_base_i = $urandom;
      load_words_i = 16'($urandom);
      byte_valid_i = idx < 4 * n && $urandom_range(99) >= gap;
      byte_data_i = idx < 4 * n ? b[idx] : 8'($urandom);
      @(negedge clk);
      if (last) begin
        check("done", load_done_o, 1);
        check("done_busy", load_busy_o, 0);
        check("done_stall", stallreq_o, 0);
        check("done_rd", cpu_data_o, exp_mem[req[11:2]]);
        if (gap == 0) check("latency", t, 5 * n + 1);
        fin = 1;
      end else if (wr) begin
        a = {base[31:2], 2'b00} + 32'(4 * w);
        d = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
        check("wr_ctl", {ram_ce_o, ram_we_o, ram_sel_o}, 6'h3f);
        check("wr_addr", ram_addr_o, a);
        check("wr_data", ram_data_o, d);
        check("wr_rdy", byte_ready_o, 0);
        check("wr_stall", stallreq_o, 1);
        exp_mem[a[11:2]] = d;
        w++;
        wr = 0;
        last = w == n;
      end else begin
        check("rx_rdy", byte_ready_o, 1);
        check("rx_ce", ram_ce_o, 0);
        check("rx_stall", stallreq_o, 1);
        check("rx_cpu", cpu_data_o, 0);
        check("rx_busy", load_busy_o, 1);
        check("rx_done", load_done_o, 0);
        if (byte_valid_i) begin
          idx++;
          wr = idx % 4 == 0;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    check("finished", fin, 1);
    load_start_i = 0;
    byte_valid_i = 0;
    cpu_ce_i = 0;
  endtask

  initial begin
    logic [7:0] q[$];
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      exp_mem[i] = mem[i];
    end
    cpu_ce_i = 1;
    cpu_we_i = 1;
    cpu_sel_i = 4'hf;
    cpu_addr_i = 32'h40;
    cpu_data_i = 32'hdeadbeef;
    repeat (2) begin
      @(negedge clk);
      check("rst_out", {ram_ce_o, stallreq_o, byte_ready_o, load_busy_o, load_done_o}, 0);
      check("rst_cpu", cpu_data_o, 0);
    end
    @(posedge clk); #1;
    rst = 0;
    cpu_data_i = $urandom;
    @(negedge clk);
    check("pt_ctl", {ram_ce_o, ram_we_o, ram_sel_o}, 6'h3f);
    check("pt_addr", ram_addr_o, 32'h40);
    check("pt_data", ram_data_o, cpu_data_i);
    exp_mem[16] = cpu_data_i;
    @(posedge clk); #1;
    cpu_we_i = 0;
    @(negedge clk);
    check("pt_rd", cpu_data_o, exp_mem[16]);
    @(posedge clk); #1;
    cpu_ce_i = 0;

    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(32'h100, 2, q, 0, 32'h200, 0);
    cpu_ce_i = 1;
    cpu_addr_i = 32'h104;
    @(negedge clk);
    check("rd_104", cpu_data_o, 32'h55667788);
    @(posedge clk); #1;
    cpu_ce_i = 0;

    run_load(32'h102, 2, q, 40, 32'h100, 1);

    load_start_i = 1;
    load_words_i = 0;
    @(posedge clk); #1;
    load_start_i = 0;
    @(negedge clk);
    check("zero_done", load_done_o, 1);
    check("zero_we", ram_we_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero_idle", {load_done_o, load_busy_o}, 0);

    load_start_i = 1;
    load_base_i = 32'h300;
    load_words_i = 1;
    @(posedge clk); #1;
    load_start_i = 0;
    byte_valid_i = 1;
    byte_data_i = 8'haa;
    @(posedge clk); #1;
    byte_data_i = 8'hbb;
    @(posedge clk); #1;
    rst = 1;
    byte_valid_i = 0;
    cpu_ce_i = 1;
    cpu_addr_i = 32'h300;
    @(negedge clk);
    check("mrst_out", {ram_ce_o, stallreq_o, byte_ready_o, load_busy_o, load_done_o}, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) begin
      @(negedge clk);
      check("mrst_idle", {load_busy_o, load_done_o, stallreq_o}, 0);
      check("mrst_mem", cpu_data_o, exp_mem[192]);
      @(posedge clk); #1;
    end
    cpu_ce_i = 0;
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(32'h300, 1, q, 0, 32'h300, 0);

    repeat (8) begin
      int n;
      n = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      run_load($urandom, n, q, $urandom_range(1) ? 0 : 35, $urandom, 1);
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
